// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared register map, control/status bits and FSM encodings
package fb_pkg;

  localparam logic [1:0] REG_BASE  = 2'd0;
  localparam logic [1:0] REG_COUNT = 2'd1;
  localparam logic [1:0] REG_VALUE = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ABORTED_BIT = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_fill_engine.sv
// rtl/fb_fill_engine.sv - memory fill engine: Avalon-MM register slave plus write master
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int COUNT_W = 24,
  parameter int STRIDE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  slave_address,
  input  logic        slave_read_en,
  input  logic        slave_write_en,
  output logic [31:0] slave_read_data,
  input  logic [31:0] slave_write_data,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_write_data,
  input  logic        master_wait_request,
  output logic        irq
);

  fb_state_e          state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        value_q, value_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  // COUNT doubles as the remaining-word counter so reads show live progress
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               abort_pend_q, abort_pend_d;

  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic accept;
  logic stop_now;

  assign ctrl_wr   = slave_write_en && (slave_address == REG_CTRL);
  assign start_req = ctrl_wr && slave_write_data[CTRL_START_BIT];
  assign abort_req = ctrl_wr && slave_write_data[CTRL_ABORT_BIT];
  assign accept    = (state_q == ST_WRITE) && !master_wait_request;
  assign stop_now  = abort_pend_q || abort_req;

  assign master_write      = (state_q == ST_WRITE);
  assign master_address    = addr_q;
  assign master_write_data = data_q;
  assign irq               = done_q;

  // zero-wait-state register read mux
  always_comb begin
    slave_read_data = '0;
    case (slave_address)
      REG_BASE:  slave_read_data = base_q;
      REG_COUNT: slave_read_data[COUNT_W-1:0] = count_q;
      REG_VALUE: slave_read_data = value_q;
      default: begin
        slave_read_data[STAT_BUSY_BIT]    = (state_q == ST_WRITE);
        slave_read_data[STAT_DONE_BIT]    = done_q;
        slave_read_data[STAT_ABORTED_BIT] = aborted_q;
      end
    endcase
  end

  // next-state: register writes, start/abort handling and word issue
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    value_d      = value_q;
    addr_d       = addr_q;
    data_d       = data_q;
    count_d      = count_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;

    // status read clears sticky bits; completion below overrides in the same cycle
    if (slave_read_en && (slave_address == REG_CTRL)) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (slave_write_en) begin
          case (slave_address)
            REG_BASE:  base_d  = {slave_write_data[31:2], 2'b00};
            REG_COUNT: count_d = slave_write_data[COUNT_W-1:0];
            REG_VALUE: value_d = slave_write_data;
            default: begin
              if (start_req) begin
                if (abort_req) begin
                  done_d    = 1'b1;
                  aborted_d = 1'b1;
                end else if (count_q == '0) begin
                  done_d    = 1'b1;
                  aborted_d = 1'b0;
                end else begin
                  addr_d    = base_q;
                  data_d    = value_q;
                  done_d    = 1'b0;
                  aborted_d = 1'b0;
                  state_d   = ST_WRITE;
                end
              end
            end
          endcase
        end
      end
      default: begin
        if (accept) begin
          addr_d  = addr_q + 32'(STRIDE);
          count_d = count_q - 1'b1;
          if ((count_q == COUNT_W'(1)) || stop_now) begin
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            aborted_d    = stop_now;
            abort_pend_d = 1'b0;
          end
        end else if (abort_req) begin
          abort_pend_d = 1'b1;
        end
      end
    endcase
  end

  // state and register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      value_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      value_q      <= value_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      count_q      <= count_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
    end
  end

endmodule

// File: tb/tb_fb_fill_engine.sv
// tb/tb_fb_fill_engine.sv - scoreboard bench for fb_fill_engine
module tb_fb_fill_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  slave_address = 2'd0;
  logic        slave_read_en = 1'b0;
  logic        slave_write_en = 1'b0;
  logic [31:0] slave_read_data;
  logic [31:0] slave_write_data = 32'd0;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_write_data;
  logic        master_wait_request = 1'b0;
  logic        irq;

  fb_fill_engine dut (
    .clk                 (clk),
    .rst                 (rst),
    .slave_address       (slave_address),
    .slave_read_en       (slave_read_en),
    .slave_write_en      (slave_write_en),
    .slave_read_data     (slave_read_data),
    .slave_write_data    (slave_write_data),
    .master_address      (master_address),
    .master_write        (master_write),
    .master_write_data   (master_write_data),
    .master_wait_request (master_wait_request),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t    exp_q[$];
  int     checks = 0;
  int     passes = 0;
  int     wr_mode = 0;
  int     phase = 0;
  int     stall_at = 0;
  int     acc_count = 0;
  longint cyc = 0;
  longint first_acc = -1;
  longint last_acc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // reference model: a fill is count words at base, base+4, ... of the same value
  task automatic push_expected(input logic [31:0] base, input int n, input logic [31:0] value);
    logic [31:0] a;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: a, data: value});
      a = a + 32'd4;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // wait_request driver, updated just after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    case (wr_mode)
      0: master_wait_request = 1'b0;
      1: master_wait_request = 1'b1;
      2: begin
        master_wait_request = master_write && (phase < 2);
        phase = master_write ? ((phase == 2) ? 0 : phase + 1) : 0;
      end
      3: master_wait_request = 1'($urandom_range(0, 1));
      default: master_wait_request = (acc_count >= stall_at);
    endcase
  end

  // monitor: every presented word must match the scoreboard head; pop on acceptance
  always @(negedge clk) begin
    if (!rst && master_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                 master_address, master_write_data);
      end else begin
        check("sb_addr", master_address, exp_q[0].addr);
        check("sb_data", master_write_data, exp_q[0].data);
        if (!master_wait_request) void'(exp_q.pop_front());
      end
      if (!master_wait_request) begin
        acc_count++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address    = a;
    slave_write_data = d;
    slave_write_en   = 1'b1;
    @(posedge clk);
    #1 slave_write_en = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read_en = 1'b1;
    #1 d = slave_read_data;
    @(posedge clk);
    #1 slave_read_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    for (int i = 0; i < limit && !irq; i++) @(posedge clk);
    #1 check(name, irq, 1'b1);
  endtask

  task automatic start_fill(input logic [31:0] base, input logic [31:0] count,
                            input logic [31:0] value);
    reg_write(2'd0, base);
    reg_write(2'd1, count);
    reg_write(2'd2, value);
    reg_write(2'd3, 32'd1);
  endtask

  // directed scenarios followed by randomized fills
  initial begin
    logic [31:0] rd;
    logic [31:0] base;
    logic [31:0] value;
    int          cnt;
    int          acc0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_master_write", master_write, 1'b0);
    check("reset_irq", irq, 1'b0);
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), rd);
      check("reset_reg", rd, 32'd0);
    end

    // basic fill, one word per cycle
    wr_mode = 0;
    acc0 = acc_count;
    first_acc = -1;
    push_expected(32'h0010_0000, 4, 32'hDEAD_BEEF);
    start_fill(32'h0010_0000, 32'd4, 32'hDEAD_BEEF);
    wait_done("basic_done", 50);
    check("basic_count", 32'(acc_count - acc0), 32'd4);
    check("basic_back_to_back", 32'(last_acc - first_acc), 32'd3);
    reg_read(2'd3, rd);
    check("basic_status", rd, 32'b010);
    #1 check("basic_irq_cleared", irq, 1'b0);

    // back-pressure: two stall cycles per word
    wr_mode = 2;
    acc0 = acc_count;
    push_expected(32'h0000_2000, 3, 32'h1234_5678);
    start_fill(32'h0000_2000, 32'd3, 32'h1234_5678);
    wait_done("bp_done", 100);
    check("bp_count", 32'(acc_count - acc0), 32'd3);
    reg_read(2'd3, rd);
    check("bp_status", rd, 32'b010);

    // zero count: done on the next cycle, no traffic
    wr_mode = 0;
    acc0 = acc_count;
    reg_write(2'd1, 32'd0);
    check("zero_irq_before", irq, 1'b0);
    reg_write(2'd3, 32'd1);
    check("zero_irq_next_cycle", irq, 1'b1);
    repeat (5) @(posedge clk);
    check("zero_no_writes", 32'(acc_count - acc0), 32'd0);
    reg_read(2'd3, rd);
    check("zero_status", rd, 32'b010);

    // abort while word 11 is stalled
    acc0 = acc_count;
    stall_at = acc_count + 10;
    wr_mode = 4;
    push_expected(32'h0004_0000, 11, 32'hA5A5_0011);
    start_fill(32'h0004_0000, 32'd100, 32'hA5A5_0011);
    for (int i = 0; i < 100 && acc_count < stall_at; i++) @(posedge clk);
    check("abort_reached_10", 32'(acc_count - acc0), 32'd10);
    repeat (3) @(posedge clk);
    reg_write(2'd3, 32'd2);
    wr_mode = 0;
    wait_done("abort_done", 50);
    check("abort_count", 32'(acc_count - acc0), 32'd11);
    reg_read(2'd1, rd);
    check("abort_remaining", rd, 32'd89);
    reg_read(2'd3, rd);
    check("abort_status", rd, 32'b110);

    // wrap past the top of the address space, then read-to-clear
    wr_mode = 3;
    push_expected(32'hFFFF_FFF8, 3, 32'h0BAD_F00D);
    start_fill(32'hFFFF_FFF8, 32'd3, 32'h0BAD_F00D);
    wait_done("wrap_done", 100);
    check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
    reg_read(2'd3, rd);
    check("wrap_status", rd, 32'b010);
    reg_read(2'd3, rd);
    check("wrap_status_cleared", rd, 32'd0);

    // START and ABORT together in IDLE
    acc0 = acc_count;
    reg_write(2'd1, 32'd5);
    reg_write(2'd3, 32'd3);
    repeat (5) @(posedge clk);
    check("startabort_no_writes", 32'(acc_count - acc0), 32'd0);
    reg_read(2'd3, rd);
    check("startabort_status", rd, 32'b110);

    // randomized fills; BASE/VALUE writes while busy must be ignored
    for (int t = 0; t < 6; t++) begin
      base  = $urandom;
      value = $urandom;
      cnt   = $urandom_range(8, 24);
      wr_mode = (t % 2 == 0) ? 3 : 0;
      acc0 = acc_count;
      push_expected(base, cnt, value);
      start_fill(base, 32'(cnt), value);
      reg_write(2'd0, ~base);
      reg_write(2'd2, ~value);
      wait_done("rand_done", 200);
      check("rand_count", 32'(acc_count - acc0), 32'(cnt));
      reg_read(2'd0, rd);
      check("rand_base_kept", rd, {base[31:2], 2'b00});
      reg_read(2'd2, rd);
      check("rand_value_kept", rd, value);
      reg_read(2'd1, rd);
      check("rand_count_zero", rd, 32'd0);
      reg_read(2'd3, rd);
      check("rand_status", rd, 32'b010);
    end

    // reset during a stalled write
    wr_mode = 1;
    push_expected(32'h0008_0000, 10, 32'h7777_0000);
    start_fill(32'h0008_0000, 32'd10, 32'h7777_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_write", master_write, 1'b0);
    check("reset_mid_irq", irq, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    wr_mode = 0;
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), rd);
      check("reset_mid_reg", rd, 32'd0);
    end
    check("reset_mid_addr", master_address, 32'd0);
    check("reset_mid_data", master_write_data, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_fill_engine.md
FB_FILL_ENGINE -- requirements
Module: fb_fill_engine

Interface
REQ-001 SHALL have parameter COUNT_W, default 24, width of the word-count register.
REQ-002 SHALL have parameter STRIDE, default 4, byte increment between successive 32-bit words.
REQ-003 SHALL have ports clk input 1, system clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have ports slave_address input 2, slave_read_en input 1, slave_write_en input 1, slave_read_data output 32, slave_write_data input 32 (Avalon-MM slave, zero read latency).
REQ-005 SHALL have ports master_address output 32, master_write output 1, master_write_data output 32, master_wait_request input 1 (Avalon-MM write master to SDRAM).
REQ-006 SHALL have port irq output 1, level-high copy of the DONE status bit.

Function
REQ-007 SHALL map registers: 0 BASE (byte address, RW), 1 COUNT (words, RW; read returns live remaining count), 2 VALUE (fill word, RW), 3 CTRL/STATUS.
REQ-008 SHALL force BASE[1:0] to 0 on write; COUNT write SHALL keep bits [COUNT_W-1:0] only; reads of unused bits SHALL return 0.
REQ-009 SHALL decode a CTRL write as bit0 START, bit1 ABORT; a STATUS read SHALL return bit0 BUSY, bit1 DONE, bit2 ABORTED.
REQ-010 SHALL drive slave_read_data combinationally from slave_address with no wait states.
REQ-011 SHALL implement FSM states IDLE and WRITE.
REQ-012 SHALL, in IDLE on START with COUNT!=0, load the address counter from BASE and the remaining counter from COUNT, clear DONE and ABORTED, and enter WRITE on the next cycle.
REQ-013 SHALL, on START with COUNT==0, stay in IDLE and set DONE on the next cycle with no master traffic.
REQ-014 SHALL, in WRITE, assert master_write with master_address = address counter and master_write_data = VALUE latched at START.
REQ-015 SHALL hold master_address, master_write_data and master_write stable while master_wait_request is high.
REQ-016 SHALL, on each cycle with master_write high and master_wait_request low, add STRIDE to the address counter (modulo 2^32, wrap permitted) and decrement remaining by 1.
REQ-017 SHALL, when the accepted word has remaining==1, deassert master_write the following cycle, return to IDLE and set DONE.
REQ-018 SHALL sustain one word per cycle when master_wait_request stays low.
REQ-019 SHALL, on ABORT in WRITE, finish the word currently presented (wait until accepted), issue no further words, return to IDLE, and set ABORTED and DONE.
REQ-020 SHALL ignore ABORT in IDLE, START in WRITE, and writes to BASE/COUNT/VALUE while BUSY.
REQ-021 SHALL apply ABORT if START and ABORT are written together in IDLE: no words issued, DONE and ABORTED set.
REQ-022 SHALL clear DONE and ABORTED on a STATUS read (slave_read_en, address 3), except that a same-cycle completion SHALL leave DONE set.
REQ-023 SHALL assert BUSY exactly while in WRITE.

Reset
REQ-024 SHALL, on rst high, asynchronously enter IDLE and clear BASE, COUNT, VALUE, counters, DONE, ABORTED; master_write=0, master_address=0, master_write_data=0, irq=0.
REQ-025 SHALL, on reset mid-transfer, drop master_write immediately; the partially filled region is left as-is.

Structure
REQ-026 SHALL take register offsets, CTRL/STATUS bit positions and FSM state encodings from a shared package, fb_pkg, also used by the display controller.
REQ-027 SHALL be a single module with no sub-modules; the Avalon slave decode SHALL stay inline.

Verification
REQ-028 Basic fill: BASE=0x0010_0000, COUNT=4, VALUE=0xDEADBEEF, START, wait_request=0 -> writes to 0x100000/04/08/0C on 4 consecutive cycles, then DONE=1, irq=1.
REQ-029 Back-pressure: COUNT=3, wait_request high 2 cycles per word -> each address/data held stable while stalled, exactly 3 accepted writes, STATUS=0b010.
REQ-030 Zero count: COUNT=0, START -> no master_write ever, DONE=1 one cycle after START.
REQ-031 Abort: COUNT=100, ABORT after 10 accepted words while word 11 is stalled -> word 11 completes, 11 total writes, STATUS=0b110, COUNT reads 89.
REQ-032 Wrap and read-clear: BASE=0xFFFF_FFF8, COUNT=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; STATUS read returns DONE=1, next read returns 0.
REQ-033 Reset mid-operation: rst asserted during a stalled write -> master_write low in the same cycle, all registers read 0 afterwards.
